// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the I/D memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DefAddrSize = 32;
  localparam int unsigned DefDataSize = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_pick.sv
// Two-way requester picker. MEM_ARB_RR_EN selects round-robin between I and D;
// otherwise D has fixed priority over I.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_grant,
  output owner_t winner
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    winner = OWN_I;
    if (i_req && d_req) begin
      // On contention, favour whoever did not win last time.
      winner = (last_grant == OWN_D) ? OWN_I : OWN_D;
    end else if (d_req) begin
      winner = OWN_D;
    end
  end
`else
  logic unused_pick_inputs;
  assign unused_pick_inputs = i_req ^ last_grant;

  always_comb begin
    winner = OWN_I;
    if (d_req) begin
      winner = OWN_D;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/rdy/valid memory port between fetch (I) and LSU (D), one transaction
// at a time. Define MEM_ARB_RR_EN for round-robin arbitration instead of D > I.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned addressSize = DefAddrSize,
  parameter int unsigned dataSize    = DefDataSize
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_req,
  input  logic [addressSize-1:0] i_addr,
  output logic                   i_rdy,
  output logic                   i_valid,
  output logic [dataSize-1:0]    i_rdata,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [addressSize-1:0] d_addr,
  input  logic [dataSize-1:0]    d_wdata,
  output logic                   d_rdy,
  output logic                   d_valid,
  output logic [dataSize-1:0]    d_rdata,
  output logic                   proc_req,
  output logic                   we,
  output logic [addressSize-1:0] addr,
  output logic [dataSize-1:0]    wdata,
  input  logic                   mem_rdy,
  input  logic                   valid,
  input  logic [dataSize-1:0]    rdata,
  output logic                   busy,
  output logic                   owner
);

  arb_state_t             state_q, state_d;
  owner_t                 owner_q, owner_d;
  logic [addressSize-1:0] addr_q, addr_d;
  logic [dataSize-1:0]    wdata_q, wdata_d;
  logic                   we_q, we_d;
  owner_t                 winner;

  // owner_q always holds the last granted requester, so it doubles as last-grant state.
  arb_pick u_arb_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (owner_q),
    .winner     (winner)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d = REQ;
          owner_d = winner;
          if (winner == OWN_D) begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end else begin
            addr_d  = i_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
        end
      end
      REQ: begin
        if (mem_rdy) begin
          state_d = valid ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  logic in_req, accept, resp;

  always_comb begin
    in_req = (state_q == REQ);
    accept = in_req && mem_rdy;
    // A response counts only in WAIT, or in REQ together with the accept.
    resp   = valid && (accept || (state_q == WAIT));
  end

  assign proc_req = in_req;
  assign we       = we_q && in_req;
  assign addr     = addr_q;
  assign wdata    = wdata_q;
  assign busy     = (state_q != IDLE);
  assign owner    = owner_q;

  assign i_rdy   = accept && (owner_q == OWN_I);
  assign d_rdy   = accept && (owner_q == OWN_D);
  assign i_valid = resp && (owner_q == OWN_I);
  assign d_valid = resp && (owner_q == OWN_D);
  assign i_rdata = i_valid ? rdata : '0;
  assign d_rdata = d_valid ? rdata : '0;

endmodule
